// File: rtl/cpu_pkg.sv
//==============================================================================
// Module : cpu_pkg
// Brief  : Shared datapath widths, memory/write-back control bundle and cause codes.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // Cause code for a trapped signed arithmetic overflow
    localparam logic [4:0] EXC_OVF = 5'd12;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } mem_wb_ctl_t;

endpackage

`default_nettype wire

// File: rtl/ovf_trap_unit.sv
//==============================================================================
// Module : ovf_trap_unit
// Brief  : Overflow trap state: sticky pending flag, faulting PC, saturating count.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ovf_trap_unit #(
    parameter int DATA_W    = 32,
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 set,
    input  logic                 ack,
    input  logic [DATA_W-1:0]    fault_pc,
    output logic                 exc_pending,
    output logic [DATA_W-1:0]    exc_epc,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    logic                 r_pending;
    logic [DATA_W-1:0]    r_epc;
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    // set cannot coincide with a pending trap because the stage stalls intake
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_epc     <= '0;
            r_ovf_cnt <= '0;
        end else if (set) begin
            r_pending <= 1'b1;
            r_epc     <= fault_pc;
            if (r_ovf_cnt != '1)
                r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
        end else if (ack) begin
            r_pending <= 1'b0;
        end
    end

    assign exc_pending = r_pending;
    assign exc_epc     = r_epc;
    assign ovf_cnt     = r_ovf_cnt;

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
//==============================================================================
// Module : ex_mem_stage
// Brief  : EX/MEM pipeline register with branch resolution and overflow trap.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W    = cpu_pkg::DATA_W,
    parameter int REG_AW    = cpu_pkg::REG_AW,
    parameter int CNT_W     = 32,
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    input  logic [DATA_W-1:0]    pc_plus4,
    input  logic [DATA_W-1:0]    branch_target,
    input  logic [DATA_W-1:0]    store_data,
    input  logic [REG_AW-1:0]    write_reg,
    input  logic                 ctl_reg_write,
    input  logic                 ctl_mem_read,
    input  logic                 ctl_mem_write,
    input  logic                 ctl_mem_to_reg,
    input  logic                 ctl_branch,
    input  logic                 ctl_branch_ne,
    input  logic                 ctl_trap_ovf,
    input  logic                 flush_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_result,
    output logic [DATA_W-1:0]    out_store_data,
    output logic [REG_AW-1:0]    out_write_reg,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic                 out_mem_to_reg,
    output logic                 branch_taken,
    output logic [DATA_W-1:0]    branch_pc,
    output logic                 exc_pending,
    output logic [DATA_W-1:0]    exc_epc,
    input  logic                 exc_ack,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    logic                w_accept;
    logic                w_trap;
    logic                w_taken;
    mem_wb_ctl_t         w_ctl;
    logic                r_valid;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_store_data;
    logic [REG_AW-1:0]   r_write_reg;
    mem_wb_ctl_t         r_ctl;
    logic                r_taken;
    logic [DATA_W-1:0]   r_branch_pc;
    logic [CNT_W-1:0]    r_retire_cnt;

    assign in_ready = (~r_valid | out_ready) & ~exc_pending & ~flush_i;
    assign w_accept = in_valid & in_ready;
    assign w_trap   = w_accept & ctl_trap_ovf & alu_overflow;
    assign w_taken  = w_accept & ctl_branch & (alu_zero ^ ctl_branch_ne);

    // A trapped instruction must not touch the register file or memory
    always_comb begin
        w_ctl.reg_write  = ctl_reg_write;
        w_ctl.mem_read   = ctl_mem_read;
        w_ctl.mem_write  = ctl_mem_write;
        w_ctl.mem_to_reg = ctl_mem_to_reg;
        if (ctl_trap_ovf && alu_overflow) begin
            w_ctl.reg_write = 1'b0;
            w_ctl.mem_read  = 1'b0;
            w_ctl.mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_write_reg  <= '0;
            r_ctl        <= '0;
            r_taken      <= 1'b0;
            r_branch_pc  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_taken <= w_taken;
            if (w_taken)
                r_branch_pc <= branch_target;
            if (flush_i) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid      <= 1'b1;
                r_result     <= alu_result;
                r_store_data <= store_data;
                r_write_reg  <= write_reg;
                r_ctl        <= w_ctl;
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    ovf_trap_unit #(
        .DATA_W    (DATA_W),
        .OVF_CNT_W (OVF_CNT_W)
    ) u_ovf_trap (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .set         (w_trap),
        .ack         (exc_ack),
        .fault_pc    (pc_plus4 - DATA_W'(4)),
        .exc_pending (exc_pending),
        .exc_epc     (exc_epc),
        .ovf_cnt     (ovf_cnt)
    );

    assign out_valid      = r_valid;
    assign out_result     = r_result;
    assign out_store_data = r_store_data;
    assign out_write_reg  = r_write_reg;
    assign out_reg_write  = r_ctl.reg_write;
    assign out_mem_read   = r_ctl.mem_read;
    assign out_mem_write  = r_ctl.mem_write;
    assign out_mem_to_reg = r_ctl.mem_to_reg;
    assign branch_taken   = r_taken;
    assign branch_pc      = r_branch_pc;
    assign retire_cnt     = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
//==============================================================================
// Module : tb_ex_mem_stage
// Brief  : Scoreboard bench for ex_mem_stage, plus a narrow-counter instance.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        in_valid, alu_zero, alu_overflow;
    logic [31:0] alu_result, pc_plus4, branch_target, store_data;
    logic [4:0]  write_reg;
    logic        ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg;
    logic        ctl_branch, ctl_branch_ne, ctl_trap_ovf, flush_i;
    logic        out_ready, exc_ack;

    logic        in_ready, out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
    logic [31:0] out_result, out_store_data, branch_pc, exc_epc, retire_cnt;
    logic [4:0]  out_write_reg;
    logic        branch_taken, exc_pending;
    logic [15:0] ovf_cnt;

    logic        s_in_ready, s_out_valid, s_rw, s_mr, s_mw, s_m2r, s_bt, s_exc;
    logic [31:0] s_res, s_sd, s_bpc, s_epc, s_ret;
    logic [4:0]  s_wr;
    logic [1:0]  s_ovf_cnt;

    always #5 clk_i = ~clk_i;

    ex_mem_stage dut (
        .clk_i(clk_i), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .pc_plus4(pc_plus4), .branch_target(branch_target), .store_data(store_data),
        .write_reg(write_reg), .ctl_reg_write(ctl_reg_write), .ctl_mem_read(ctl_mem_read),
        .ctl_mem_write(ctl_mem_write), .ctl_mem_to_reg(ctl_mem_to_reg),
        .ctl_branch(ctl_branch), .ctl_branch_ne(ctl_branch_ne), .ctl_trap_ovf(ctl_trap_ovf),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_write_reg(out_write_reg),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .branch_taken(branch_taken), .branch_pc(branch_pc),
        .exc_pending(exc_pending), .exc_epc(exc_epc), .exc_ack(exc_ack),
        .retire_cnt(retire_cnt), .ovf_cnt(ovf_cnt)
    );

    // Same stimulus, 2-bit overflow counter so saturation is reachable quickly
    ex_mem_stage #(.OVF_CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .pc_plus4(pc_plus4), .branch_target(branch_target), .store_data(store_data),
        .write_reg(write_reg), .ctl_reg_write(ctl_reg_write), .ctl_mem_read(ctl_mem_read),
        .ctl_mem_write(ctl_mem_write), .ctl_mem_to_reg(ctl_mem_to_reg),
        .ctl_branch(ctl_branch), .ctl_branch_ne(ctl_branch_ne), .ctl_trap_ovf(ctl_trap_ovf),
        .flush_i(flush_i), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_result(s_res), .out_store_data(s_sd), .out_write_reg(s_wr),
        .out_reg_write(s_rw), .out_mem_read(s_mr), .out_mem_write(s_mw),
        .out_mem_to_reg(s_m2r), .branch_taken(s_bt), .branch_pc(s_bpc),
        .exc_pending(s_exc), .exc_epc(s_epc), .exc_ack(exc_ack),
        .retire_cnt(s_ret), .ovf_cnt(s_ovf_cnt)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  wr;
        logic        rw, mr, mw, m2r;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic        m_ov, m_bt, m_exc;
    logic [31:0] m_bpc, m_epc, m_ret;
    logic [15:0] m_ovf;
    logic [1:0]  m_ovf_s;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_bt = 0; m_exc = 0;
        m_bpc = 0; m_epc = 0; m_ret = 0; m_ovf = 0; m_ovf_s = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".out_result"}, out_result, 0);
        check({tag, ".out_store_data"}, out_store_data, 0);
        check({tag, ".out_write_reg"}, out_write_reg, 0);
        check({tag, ".ctl"}, {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg}, 0);
        check({tag, ".branch_taken"}, branch_taken, 0);
        check({tag, ".branch_pc"}, branch_pc, 0);
        check({tag, ".exc_pending"}, exc_pending, 0);
        check({tag, ".exc_epc"}, exc_epc, 0);
        check({tag, ".retire_cnt"}, retire_cnt, 0);
        check({tag, ".ovf_cnt"}, ovf_cnt, 0);
    endtask

    task automatic idle();
        in_valid = 0; alu_result = 0; alu_zero = 0; alu_overflow = 0;
        pc_plus4 = 0; branch_target = 0; store_data = 0; write_reg = 0;
        ctl_reg_write = 0; ctl_mem_read = 0; ctl_mem_write = 0; ctl_mem_to_reg = 0;
        ctl_branch = 0; ctl_branch_ne = 0; ctl_trap_ovf = 0; flush_i = 0; exc_ack = 0;
    endtask

    task automatic op(input logic [31:0] res, input logic [4:0] wr, input logic rw);
        idle();
        in_valid = 1; alu_result = res; write_reg = wr; ctl_reg_write = rw;
        store_data = res ^ 32'hA5A5_5A5A; pc_plus4 = 32'h0000_2000 + res;
    endtask

    // One clock: predict acceptance, advance the model, compare every output
    task automatic step();
        logic        rdy, acc, cons, trap, ebt, fl, ack;
        logic [31:0] tgt, pc4;
        exp_t        e;
        #1;
        rdy  = (!m_ov || out_ready) && !m_exc && !flush_i;
        check("in_ready", in_ready, rdy);
        acc  = in_valid && rdy;
        cons = m_ov && out_ready;
        trap = acc && ctl_trap_ovf && alu_overflow;
        ebt  = acc && ctl_branch && (alu_zero ^ ctl_branch_ne);
        fl = flush_i; ack = exc_ack; tgt = branch_target; pc4 = pc_plus4;
        e.res = alu_result; e.sd = store_data; e.wr = write_reg;
        e.rw  = ctl_reg_write && !(ctl_trap_ovf && alu_overflow);
        e.mr  = ctl_mem_read  && !(ctl_trap_ovf && alu_overflow);
        e.mw  = ctl_mem_write && !(ctl_trap_ovf && alu_overflow);
        e.m2r = ctl_mem_to_reg;
        @(posedge clk_i);
        #1;
        if (fl) begin
            if (m_ov) void'(q.pop_front());
            m_ov = 0;
        end else begin
            if (cons) begin
                void'(q.pop_front());
                m_ov = 0;
            end
            if (acc) begin
                q.push_back(e);
                m_ov = 1;
            end
        end
        m_bt = ebt;
        if (ebt) m_bpc = tgt;
        if (trap) begin
            m_exc = 1;
            m_epc = pc4 - 32'd4;
            if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            if (m_ovf_s != 2'b11) m_ovf_s = m_ovf_s + 2'd1;
        end else if (ack) begin
            m_exc = 0;
        end
        if (acc) m_ret = m_ret + 32'd1;

        check("out_valid", out_valid, m_ov);
        if (m_ov && q.size() > 0) begin
            check("out_result", out_result, q[0].res);
            check("out_store_data", out_store_data, q[0].sd);
            check("out_write_reg", out_write_reg, q[0].wr);
            check("out_ctl", {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg},
                  {q[0].rw, q[0].mr, q[0].mw, q[0].m2r});
        end
        check("branch_taken", branch_taken, m_bt);
        check("branch_pc", branch_pc, m_bpc);
        check("exc_pending", exc_pending, m_exc);
        check("exc_epc", exc_epc, m_epc);
        check("retire_cnt", retire_cnt, m_ret);
        check("ovf_cnt", ovf_cnt, m_ovf);
        check("ovf_cnt_sat", s_ovf_cnt, m_ovf_s);
    endtask

    task automatic trap_op(input logic [31:0] pc4);
        op(32'h7FFF_FFFF, 5'd9, 1'b1);
        ctl_trap_ovf = 1; alu_overflow = 1; pc_plus4 = pc4;
        ctl_mem_write = 1; ctl_mem_to_reg = 1;
    endtask

    initial begin
        rst_n = 0; out_ready = 1;
        idle();
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1;

        // Plain ALU op, then drain
        op(32'h0000_1234, 5'd3, 1'b1); step();
        idle(); step();

        // BEQ taken
        op(32'h0, 5'd0, 1'b0); ctl_branch = 1; alu_zero = 1; branch_target = 32'h0000_0040; step();
        idle(); step();

        // BNE with zero set: not taken, branch_pc must hold 0x40
        op(32'h0, 5'd0, 1'b0); ctl_branch = 1; ctl_branch_ne = 1; alu_zero = 1;
        branch_target = 32'h0000_0080; step();
        idle(); step();

        // Overflow without trap: controls pass unchanged
        op(32'h8000_0000, 5'd7, 1'b1); alu_overflow = 1; ctl_mem_read = 1; step();
        idle(); step();

        // Backpressure: held entry stable, then simultaneous drain and accept
        out_ready = 0;
        op(32'hAAAA_0001, 5'd4, 1'b1); step();
        op(32'hBBBB_0002, 5'd5, 1'b1); repeat (3) step();
        out_ready = 1; step();
        idle(); step();

        // Flush with a held entry and a same-cycle input
        out_ready = 0;
        op(32'hCCCC_0003, 5'd6, 1'b1); step();
        op(32'hDDDD_0004, 5'd8, 1'b1); flush_i = 1; step();
        idle(); out_ready = 1; step();

        // Overflow trap: stall until acknowledged; flush does not clear it
        trap_op(32'h0000_0104); step();
        op(32'hEEEE_0005, 5'd10, 1'b1); step();
        flush_i = 1; step();
        flush_i = 0; step();
        exc_ack = 1; step();
        exc_ack = 0; step();
        idle(); exc_ack = 1; step();
        idle(); step();

        // Asynchronous reset between edges with a held entry and pending trap
        out_ready = 0;
        trap_op(32'h0000_0300); step();
        #2;
        rst_n = 0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        idle(); out_ready = 1;
        @(negedge clk_i);
        rst_n = 1;

        // Enough traps to saturate the narrow counter instance
        for (int i = 0; i < 5; i++) begin
            trap_op(32'h0000_1000 + 32'(i * 4)); step();
            idle(); exc_ack = 1; step();
            exc_ack = 0; step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the 32-bit ALU.
- Registers the ALU result and flags together with the memory and write-back controls travelling with the instruction.
- Resolves BEQ/BNE from the ALU zero flag and traps signed add/sub overflow, holding an exception until acknowledged.
- Single-entry valid/ready buffer, plus retire and overflow counters for debug.

Parameters:
DATA_W, 32, datapath width (ALU result, PC, store data)
REG_AW, 5, register-file address width
CNT_W, 32, retire-counter width (wraps)
OVF_CNT_W, 16, overflow-counter width (saturates)

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream (EX) entry valid
in_ready  out  1  stage can accept this cycle
alu_result  in  DATA_W  ALU result
alu_zero  in  1  ALU zero flag
alu_overflow  in  1  ALU signed overflow flag
pc_plus4  in  DATA_W  PC+4 of the instruction
branch_target  in  DATA_W  computed branch target
store_data  in  DATA_W  rt value for stores
write_reg  in  REG_AW  destination register
ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg  in  1 each  memory/WB controls
ctl_branch, ctl_branch_ne  in  1 each  branch instruction; 1 = BNE, 0 = BEQ
ctl_trap_ovf  in  1  instruction is a trapping signed ADD/SUB
flush_i  in  1  kill the held entry and any same-cycle input
out_valid  out  1  held entry valid toward MEM
out_ready  in  1  MEM consumes the entry
out_result, out_store_data  out  DATA_W each  registered copies
out_write_reg  out  REG_AW  registered copy
out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  out  1 each  registered controls (gated on exception)
branch_taken  out  1  one-cycle pulse, branch resolved taken
branch_pc  out  DATA_W  target, valid with branch_taken
exc_pending  out  1  overflow trap outstanding
exc_epc  out  DATA_W  address of the faulting instruction
exc_ack  in  1  trap handler acknowledge
retire_cnt  out  CNT_W  accepted, unflushed entries
ovf_cnt  out  OVF_CNT_W  trapped overflows

Behaviour:
- Reset (async, rst_n=0): every output register is 0. This covers out_valid, all data/control outputs, branch_taken, branch_pc, exc_pending, exc_epc and both counters.
- in_ready = (~out_valid | out_ready) & ~exc_pending & ~flush_i (combinational).
- Accept = in_valid & in_ready. On accept, all inputs are registered and out_valid=1 the next cycle (latency 1).
- out_valid & out_ready with no accept: out_valid clears next cycle.
- Held entry stable while out_valid & ~out_ready; upstream inputs are ignored.
- Branch: on accept with ctl_branch & (alu_zero ^ ctl_branch_ne):
  - branch_taken=1 for exactly the next cycle; branch_pc=branch_target.
  - Otherwise branch_taken=0; branch_pc holds its last value.
  - The branch entry still flows to MEM with its controls (reg_write normally 0).
- Overflow trap: on accept with ctl_trap_ovf & alu_overflow:
  - Entry is registered with out_reg_write=0, out_mem_write=0, out_mem_read=0.
  - exc_pending=1; exc_epc = pc_plus4 - 4 (mod 2^DATA_W).
  - ovf_cnt += 1, saturating at all-ones.
  - exc_pending holds, and therefore in_ready=0, until exc_ack is sampled high. exc_pending clears the cycle after exc_ack; exc_epc retains its value.
- Non-trapping overflow (ctl_trap_ovf=0): no exception, controls pass unchanged.
- retire_cnt += 1 on every accept (including trapped entries); wraps modulo 2^CNT_W.
- flush_i=1 (highest priority):
  - out_valid=0 next cycle and branch_taken=0 next cycle.
  - in_ready=0, so there is no accept and no counter update.
  - exc_pending is unaffected; flush does not clear a trap.
- exc_ack while exc_pending=0: ignored.
- Reset mid-transfer: entry discarded, counters cleared. Upstream must not assume a transfer that had not been accepted was consumed.

Decomposition:
- Shared package cpu_pkg: DATA_W/REG_AW constants, a struct for the memory/WB control bundle, the EXC_OVF cause code.
- Natural sub-module: ovf_trap_unit, containing the exc_pending/exc_epc/ovf_cnt logic with set/ack interface.
- Pipeline register and branch logic stay in ex_mem_stage.

Test Plan:
- BEQ taken: accept ctl_branch=1, ctl_branch_ne=0, alu_zero=1, branch_target=0x0000_0040 -> next cycle branch_taken=1, branch_pc=0x40; the cycle after, branch_taken=0.
- BNE not taken: alu_zero=1, ctl_branch_ne=1 -> branch_taken stays 0; retire_cnt +1.
- Overflow trap:
  - Stimulus: ctl_trap_ovf=1, alu_overflow=1, pc_plus4=0x0000_0104, ctl_reg_write=1.
  - Required: out_reg_write=0, exc_pending=1, exc_epc=0x100, ovf_cnt=1; in_ready=0 until exc_ack, then 1 the cycle after.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, held out_result unchanged; out_ready=1 -> next entry accepted the same cycle.
- Flush priority: in_valid=1, flush_i=1, out_valid=1 -> next cycle out_valid=0, retire_cnt unchanged.
- Async reset mid-operation: drop rst_n between clock edges while out_valid=1 and exc_pending=1 -> all outputs 0 immediately; ovf_cnt saturation checked separately by forcing 0xFFFF then one more trap (stays 0xFFFF).
